// File: rtl/ppu_requant.sv
// ppu_requant: post-processing stage after the systolic array.
// Adds a per-channel bias, applies optional ReLU, requantizes each signed
// 32-bit accumulator with a round-half-up arithmetic right shift, saturates
// to int8 and packs four results into one 32-bit ofmap word with an address.
// o_done pulses one cycle after the final word of a WIDTH-element tile.
module ppu_requant #(
    parameter int WIDTH  = 64,   // results per tile, multiple of PACK
    parameter int PACK   = 4,    // int8 results per output word
    parameter int ADDR_W = 12    // output word address width
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clear,
    input  logic signed [31:0]  psum,
    input  logic signed [31:0]  bias,
    input  logic        [4:0]   shift,
    input  logic                relu_en,
    output logic                o_valid,
    output logic        [31:0]  o_data,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_done
);

    localparam int ELEM_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // S1 registers: bias-added sum plus the per-element controls
    logic                s1_valid_q, s1_valid_d;
    logic signed [32:0]  s1_sum_q, s1_sum_d;
    logic        [4:0]   s1_shift_q;
    logic                s1_relu_q;

    // S2 registers: rounded and shifted value, not yet saturated
    logic                s2_valid_q, s2_valid_d;
    logic signed [33:0]  s2_r_q, s2_r_d;

    // Packer, counters and registered outputs
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         pack_q, pack_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic                done_arm_q, done_arm_d;
    logic                o_valid_q, o_valid_d;
    logic [31:0]         o_data_q, o_data_d;
    logic [ADDR_W-1:0]   o_addr_q, o_addr_d;
    logic                o_done_q, o_done_d;

    logic signed [33:0]  x;
    logic signed [33:0]  rnd;
    logic        [7:0]   q_byte;

    // S1 next state: sign-extended add cannot overflow 33 bits; clear discards input
    always_comb begin
        s1_valid_d = i_en & ~i_clear;
        s1_sum_d   = {psum[31], psum} + {bias[31], bias};
        s2_valid_d = s1_valid_q & ~i_clear;
    end

    // S2 next state: optional ReLU, then rounding arithmetic shift in 34 bits
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        x      = {s1_sum_q[32], s1_sum_q};
        rnd    = '0;
        if (s1_relu_q && s1_sum_q[32]) begin
            x = '0;
        end
        if (s1_shift_q != 5'd0) begin
            rnd = 34'sd1 <<< (s1_shift_q - 5'd1);
        end
        s2_r_d = (x + rnd) >>> s1_shift_q;
    end

    // S3: saturate to int8
    always_comb begin
        if (s2_r_q > 34'sd127) begin
            q_byte = 8'h7F;
        end else if (s2_r_q < -34'sd128) begin
            q_byte = 8'h80;
        end else begin
            q_byte = s2_r_q[7:0];
        end
    end

    // Pack and count: lane write, word emission, tile-end detection, clear override
    always_comb begin
        lane_d     = lane_q;
        pack_d     = pack_q;
        word_d     = word_q;
        elem_d     = elem_q;
        done_arm_d = 1'b0;
        o_valid_d  = 1'b0;
        o_data_d   = o_data_q;
        o_addr_d   = o_addr_q;
        o_done_d   = done_arm_q;
        if (s2_valid_q) begin
            case (lane_q)
                2'd0:    pack_d[7:0]   = q_byte;
                2'd1:    pack_d[15:8]  = q_byte;
                2'd2:    pack_d[23:16] = q_byte;
                default: pack_d        = pack_q;
            endcase
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'(PACK - 1)) begin
                o_valid_d = 1'b1;
                o_data_d  = {q_byte, pack_q};
                o_addr_d  = word_q;
                word_d    = word_q + ADDR_W'(1);
            end
            if (elem_q == ELEM_W'(WIDTH - 1)) begin
                elem_d     = '0;
                word_d     = '0;
                lane_d     = '0;
                done_arm_d = 1'b1;
            end else begin
                elem_d = elem_q + ELEM_W'(1);
            end
        end
        if (i_clear) begin
            lane_d     = '0;
            word_d     = '0;
            elem_d     = '0;
            done_arm_d = 1'b0;
            o_valid_d  = 1'b0;
            o_done_d   = 1'b0;
        end
    end

    // Control state and outputs: synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            lane_q     <= '0;
            word_q     <= '0;
            elem_q     <= '0;
            done_arm_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_addr_q   <= '0;
            o_done_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            elem_q     <= elem_d;
            done_arm_q <= done_arm_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_addr_q   <= o_addr_d;
            o_done_q   <= o_done_d;
        end
    end

    // Datapath registers: qualified by valids or lane index, so they carry no reset
    always_ff @(posedge clk) begin
        // NOTE: data-only registers are left unreset; their valid flags and lane index gate every use.
        s1_sum_q   <= s1_sum_d;
        s1_shift_q <= shift;
        s1_relu_q  <= relu_en;
        s2_r_q     <= s2_r_d;
        pack_q     <= pack_d;
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_addr  = o_addr_q;
    assign o_done  = o_done_q;

endmodule

// File: tb/tb_ppu_requant.sv
// Directed testbench for ppu_requant: hand-computed vectors for rounding,
// saturation, ReLU, full-tile addressing/done, bubbles, clear and reset abort.
module tb_ppu_requant;

    logic               clk;
    logic               rst;
    logic               i_en;
    logic               i_clear;
    logic signed [31:0] psum;
    logic signed [31:0] bias;
    logic        [4:0]  shift;
    logic               relu_en;
    logic               o_valid;
    logic        [31:0] o_data;
    logic        [11:0] o_addr;
    logic               o_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int in_cyc;
    int last_in;

    logic [31:0] vq[$];
    logic [31:0] aq[$];
    logic [31:0] cq[$];

    ppu_requant #(.WIDTH(64), .PACK(4), .ADDR_W(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_en),
        .i_clear (i_clear),
        .psum    (psum),
        .bias    (bias),
        .shift   (shift),
        .relu_en (relu_en),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_addr  (o_addr),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output word and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            vq.push_back(o_data);
            aq.push_back(32'(o_addr));
            cq.push_back(32'(cyc));
        end
        if (o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] at(input int which, input int k);
        logic [31:0] v;
        v = 'x;
        if (which == 0 && k < vq.size()) v = vq[k];
        if (which == 1 && k < aq.size()) v = aq[k];
        if (which == 2 && k < cq.size()) v = cq[k];
        return v;
    endfunction

    task automatic send(input logic signed [31:0] p, input logic signed [31:0] b,
                        input logic [4:0] s, input logic r);
        i_en    = 1'b1;
        psum    = p;
        bias    = b;
        shift   = s;
        relu_en = r;
        last_in = cyc;
        @(posedge clk); #1;
        i_en    = 1'b0;
    endtask

    task automatic idle(input int n);
        i_en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
    endtask

    task automatic flush_log();
        vq.delete();
        aq.delete();
        cq.delete();
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b0; i_clear = 1'b0;
        psum = '0; bias = '0; shift = '0; relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  o_data,       32'd0);
        check("rst_addr",  32'(o_addr),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);

        // Basic: (1000+24+8)>>>4 = 64 in every lane
        repeat (4) send(1000, 24, 5'd4, 1'b0);
        in_cyc = last_in;
        idle(6);
        check("basic_count",   32'(vq.size()), 32'd1);
        check("basic_data",    at(0, 0), 32'h4040_4040);
        check("basic_addr",    at(1, 0), 32'd0);
        check("basic_latency", at(2, 0), 32'(in_cyc + 3));
        check("basic_hold",    o_data, 32'h4040_4040);
        check("basic_idle_v",  32'(o_valid), 32'd0);
        flush_log();
        do_clear();

        // Rounding and saturation, shift 3
        send(23, 0, 5'd3, 1'b0);
        send(-24, 0, 5'd3, 1'b0);
        send(5000, 0, 5'd3, 1'b0);
        send(-5000, 0, 5'd3, 1'b0);
        idle(6);
        check("round_count", 32'(vq.size()), 32'd1);
        check("round_data",  at(0, 0), 32'h807F_FD03);
        check("round_addr",  at(1, 0), 32'd0);
        flush_log();

        // ReLU on then off: -90 clamps to 0, else 0xA6; word count continues
        repeat (4) send(-100, 10, 5'd0, 1'b1);
        repeat (4) send(-100, 10, 5'd0, 1'b0);
        idle(6);
        check("relu_count",  32'(vq.size()), 32'd2);
        check("relu_on",     at(0, 0), 32'h0000_0000);
        check("relu_addr0",  at(1, 0), 32'd1);
        check("relu_off",    at(0, 1), 32'hA6A6_A6A6);
        check("relu_addr1",  at(1, 1), 32'd2);
        flush_log();
        do_clear();

        // Full tile: element i yields (16i+8)>>>4 = i
        done_cnt = 0;
        for (int i = 0; i < 64; i++) send(i * 16, 0, 5'd4, 1'b0);
        idle(6);
        check("tile_count", 32'(vq.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] exp_w;
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            check($sformatf("tile_data%0d", k), at(0, k), exp_w);
            check($sformatf("tile_addr%0d", k), at(1, k), 32'(k));
        end
        check("tile_done_cnt", 32'(done_cnt), 32'd1);
        check("tile_done_cyc", 32'(done_cyc), at(2, 15) + 32'd1);
        flush_log();

        // Second tile restarts at address 0 without a clear
        repeat (4) send(32, 0, 5'd4, 1'b0);
        idle(6);
        check("tile2_data", at(0, 0), 32'h0202_0202);
        check("tile2_addr", at(1, 0), 32'd0);
        check("tile2_nodone", 32'(done_cnt), 32'd1);
        flush_log();
        do_clear();

        // Bubbles: i_en 1,0,0,1,1,0,1
        send(1, 0, 5'd0, 1'b0);
        idle(2);
        send(2, 0, 5'd0, 1'b0);
        send(3, 0, 5'd0, 1'b0);
        idle(1);
        send(4, 0, 5'd0, 1'b0);
        in_cyc = last_in;
        idle(6);
        check("bub_count",   32'(vq.size()), 32'd1);
        check("bub_data",    at(0, 0), 32'h0403_0201);
        check("bub_addr",    at(1, 0), 32'd0);
        check("bub_latency", at(2, 0), 32'(in_cyc + 3));
        flush_log();
        do_clear();

        // Abort by clear coinciding with the 6th input: in-flight word suppressed
        repeat (5) send(64, 0, 5'd0, 1'b0);
        i_clear = 1'b1;
        send(64, 0, 5'd0, 1'b0);
        i_clear = 1'b0;
        repeat (4) send(16, 0, 5'd2, 1'b0);
        idle(6);
        check("clr_count", 32'(vq.size()), 32'd1);
        check("clr_data",  at(0, 0), 32'h0404_0404);
        check("clr_addr",  at(1, 0), 32'd0);
        check("clr_nodone", 32'(done_cnt), 32'd1);
        flush_log();

        // Abort by reset coinciding with the 6th input
        repeat (5) send(64, 0, 5'd0, 1'b0);
        rst = 1'b1;
        send(64, 0, 5'd0, 1'b0);
        rst = 1'b0;
        check("rst_mid_data",  o_data, 32'd0);
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        repeat (4) send(16, 0, 5'd2, 1'b0);
        idle(6);
        check("rstab_count", 32'(vq.size()), 32'd1);
        check("rstab_data",  at(0, 0), 32'h0404_0404);
        check("rstab_addr",  at(1, 0), 32'd0);
        check("rstab_nodone", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
